updown_sweep_ctrl: RTL

//  Sequencer for the 4-bit up/down counter datapath (clk, reset, upordown, count).
//  On a start pulse it drives the counter through a triangle sweep:
//  0 -> LO (prime), then LO -> HI -> LO, repeated CYCLES times.
//  It then parks the counter in reset and pulses done.

---
 rtl/updown_sweep_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for a W-bit up/down counter.
// Primes 0->lo, then runs lo->hi->lo for the latched number of cycles.
module updown_sweep_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic [7:0]   cycles,
    input  logic [W-1:0] count,
    output logic         upordown,
    output logic         cnt_reset,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [7:0]   sweep_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        UP,
        DOWN,
        FINISH
    } state_t;

    state_t       state;
    logic [W-1:0] lo_q;
    logic [W-1:0] hi_q;
    logic [7:0]   cyc_q;

    logic [W-1:0] hi_m1;
    logic [W-1:0] lo_p1;
    logic [7:0]   sweep_nx;

    // Turn-around is decided one count early so the extremes last one cycle.
    assign hi_m1    = hi_q - 1'b1;
    assign lo_p1    = lo_q + 1'b1;
    assign sweep_nx = sweep_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            cyc_q     <= '0;
            upordown  <= 1'b1;
            cnt_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state != IDLE && abort) begin
                cnt_reset <= 1'b1;
                upordown  <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt_reset <= 1'b1;
                        if (start) begin
                            if (lo < hi && cycles != 8'd0) begin
                                lo_q      <= lo;
                                hi_q      <= hi;
                                cyc_q     <= cycles;
                                sweep_cnt <= '0;
                                cnt_reset <= 1'b0;
                                upordown  <= 1'b1;
                                busy      <= 1'b1;
                                state     <= PRIME;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    PRIME: begin
                        if (count == hi_m1) begin
                            upordown <= 1'b0;
                            state    <= DOWN;
                        end else if (count == lo_q) begin
                            state <= UP;
                        end
                    end
                    UP: begin
                        if (count == hi_m1) begin
                            upordown <= 1'b0;
                            state    <= DOWN;
                        end
                    end
                    DOWN: begin
                        if (count == lo_p1) begin
                            sweep_cnt <= sweep_nx;
                            if (sweep_nx == cyc_q) begin
                                cnt_reset <= 1'b1;
                                done      <= 1'b1;
                                state     <= FINISH;
                            end else begin
                                upordown <= 1'b1;
                                state    <= UP;
                            end
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
